decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the RV32I pipeline, directly downstream of fetch: consumes the fetched {ir, npc}.
//  - Decodes ir and reads the register file (write port from WB).
//  - Builds sign-extended immediates and computes the PC-relative target (npc+imm) for B/JAL.
//  - Registers everything into the ID/EX pipeline register.
//  - Detects load-use hazards; the hazard unit turns stall_req into stallF/stallD.
// PARAMETERS
//  NREG     32  architectural registers (x0 hardwired zero)
//  XLEN     32  datapath width
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  reset        in   1   asynchronous, active-high; clears all state
//  ir           in   32  instruction word from fetch (32'h0 = bubble)
//  npc          in   32  PC of the instruction in ir
//  hold_e       in   1   keep ID/EX register unchanged this cycle
//  flush_e      in   1   load a bubble into ID/EX (mispredict recovery)
//  wb_we        in   1   register-file write enable
//  wb_rd        in   5   write address
//  wb_data      in   32  write data
//  stall_req    out  1   combinational load-use hazard request
//  ex_valid     out  1   ID/EX holds a real instruction
//  ex_pc        out  32  PC of the EX instruction
//  ex_link      out  32  ex_pc+4 (JAL/JALR link value)
//  ex_imm       out  32  sign-extended immediate (I/S/B/U/J by opcode, 0 for R)
//  ex_target    out  32  npc+imm for B/JAL, else 0
//  ex_rs1 / ex_rs2      out 5   source register numbers
//  ex_rs1_val / ex_rs2_val out 32 source operands
//  ex_rd        out  5   destination register
//  ex_opcode    out  7   ir[6:0]
//  ex_funct3    out  3   ir[14:12]
//  ex_funct7b5  out  1   ir[30]
//  ex_reg_we    out  1   writes rd (forced 0 when rd==0)
//  ex_is_load / ex_is_store / ex_is_branch / ex_is_jal / ex_is_jalr  out 1 class flags
//  ex_illegal   out  1   unknown opcode
// BEHAVIOUR
//  - Reset (async, any cycle, including mid-stall/flush):
//    - all ex_* outputs go to 0 immediately; all 32 registers are cleared.
//    - stall_req is then 0, because ex_is_load=0.
//  - Latency: decode is 1 cycle; ir/npc presented at edge N appear on ex_* after edge N+1.
//  - ID/EX update priority each edge: reset > flush_e (bubble) > hold_e (keep) > stall_req (bubble) > load decoded ir.
//  - Bubble: ex_valid=0, ex_reg_we=0, all class flags=0, ex_illegal=0; other fields don't-care but driven to 0.
//  - ir==32'h0 decodes as a bubble. Unknown opcode -> ex_valid=1, ex_illegal=1, ex_reg_we=0.
//  - Register file:
//    - 2 combinational read ports, 1 synchronous write port; a write to x0 is discarded; reads of x0 return 0.
//    - Write-through: if wb_we and wb_rd==rsN and rsN!=0 in the same cycle, the read returns wb_data.
//  - Register usage:
//    - rs1 is used by all opcodes except LUI, AUIPC and JAL.
//    - rs2 is used by R-type, STORE and BRANCH.
//    - Unused rsN fields are still output, but never cause stall_req.
//  - stall_req = ex_valid & ex_is_load & ex_rd!=0 & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)).
//    The hazard unit holds ir/npc (stallD) on the same edge, so the dependent instruction reissues one cycle later.
//  - Arithmetic: ex_target and ex_link wrap mod 2^32 (e.g. npc=32'hFFFF_FFFC, imm=8 -> 32'h4). JALR target is computed in EX.
//  - flush_e together with stall_req -> single bubble; flush_e together with hold_e -> flush wins.
// STRUCTURE
//  - 99_define.vh gains these constants: opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
//    OP_STORE, OP_IMM, OP_REG), plus `TRUE/`FALSE reuse.
//  - Sub-module regfile (2R1W, write-through, x0=0, async clear) instantiated once.
//  - Decode, immediate generation and hazard compare stay flat in decode_stage.
// TESTING
//  1 Reset pulsed high mid-stream -> all ex_* = 0 the same cycle; after release x1..x31 read 0.
//  2 ir=32'h00500093 (addi x1,x0,5), npc=32'h8000 -> next edge: ex_valid=1, ex_rd=1, ex_imm=5, ex_reg_we=1, ex_pc=32'h8000.
//  3 wb_we=1, wb_rd=2, wb_data=32'hDEADBEEF in the same cycle as ir=32'h002101B3 (add x3,x2,x2)
//    -> ex_rs1_val = ex_rs2_val = 32'hDEADBEEF.
//  4 ir=32'hFE000CE3 (beq x0,x0,-8), npc=32'h8010 -> ex_is_branch=1, ex_imm=32'hFFFFFFF8, ex_target=32'h8008, ex_reg_we=0.
//  5 EX holds 32'h0000A283 (lw x5,0(x1)) and ir=32'h00028333 (add x6,x5,x0) -> stall_req=1.
//    - Next edge: ex_valid=0.
//    - Following edge: add enters EX with ex_rs1=5.
//  6 flush_e=1 with hold_e=1 -> bubble.
//    - Writes to x0 with 32'h1234 leave x0 reads at 0.
//    - ir=32'h0000007F -> ex_illegal=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared constants, the ID/EX record and immediate generation for the RV32I decode stage.
package decode_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned RADDR = $clog2(NREG);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  link;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             reg_we;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             illegal;
  } id_ex_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ir);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (ir[6:0])
      OP_JALR, OP_LOAD, OP_IMM: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                 imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {ir[31:12], 12'b0};
      OP_JAL:                   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 2-read/1-write register file with write-through reads, x0 hardwired to zero, async clear.
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RADDR-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [RADDR-1:0] raddr1,
  input  logic [RADDR-1:0] raddr2,
  output logic [XLEN-1:0]  rdata1,
  output logic [XLEN-1:0]  rdata2
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we && waddr != '0) begin
      regs_q[waddr] <= wdata;
    end
  end

  // The WB value is forwarded so ID sees a result written in the same cycle.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decode, register read, immediates, branch/JAL target, load-use hazard, ID/EX reg.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir,
  input  logic [XLEN-1:0]  npc,
  input  logic             hold_e,
  input  logic             flush_e,
  input  logic             wb_we,
  input  logic [RADDR-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall_req,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_link,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_target,
  output logic [RADDR-1:0] ex_rs1,
  output logic [RADDR-1:0] ex_rs2,
  output logic [XLEN-1:0]  ex_rs1_val,
  output logic [XLEN-1:0]  ex_rs2_val,
  output logic [RADDR-1:0] ex_rd,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_reg_we,
  output logic             ex_is_load,
  output logic             ex_is_store,
  output logic             ex_is_branch,
  output logic             ex_is_jal,
  output logic             ex_is_jalr,
  output logic             ex_illegal
);

  id_ex_t          dec, ex_q;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            writes_rd, rs1_used, rs2_used;

  decode_stage_regfile u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (ir[19:15]),
    .raddr2 (ir[24:20]),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    dec       = '0;
    writes_rd = 1'b0;
    if (ir != '0) begin
      dec.valid    = 1'b1;
      dec.pc       = npc;
      dec.link     = npc + XLEN'(4);
      dec.imm      = gen_imm(ir);
      dec.rs1      = ir[19:15];
      dec.rs2      = ir[24:20];
      dec.rd       = ir[11:7];
      dec.rs1_val  = rs1_val;
      dec.rs2_val  = rs2_val;
      dec.opcode   = ir[6:0];
      dec.funct3   = ir[14:12];
      dec.funct7b5 = ir[30];
      case (ir[6:0])
        OP_LUI, OP_AUIPC, OP_IMM, OP_REG: writes_rd = 1'b1;
        OP_JAL:    begin dec.is_jal  = 1'b1; writes_rd = 1'b1; end
        OP_JALR:   begin dec.is_jalr = 1'b1; writes_rd = 1'b1; end
        OP_LOAD:   begin dec.is_load = 1'b1; writes_rd = 1'b1; end
        OP_STORE:  dec.is_store  = 1'b1;
        OP_BRANCH: dec.is_branch = 1'b1;
        default:   dec.illegal   = 1'b1;
      endcase
      if (dec.is_branch || dec.is_jal) dec.target = npc + dec.imm;
      dec.reg_we = writes_rd && (dec.rd != '0);
    end
  end

  // Only fields an opcode actually reads may raise a load-use stall.
  always_comb begin
    rs1_used  = !(ir[6:0] inside {OP_LUI, OP_AUIPC, OP_JAL});
    rs2_used  = ir[6:0] inside {OP_REG, OP_STORE, OP_BRANCH};
    stall_req = ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                ((rs1_used && ex_q.rd == ir[19:15]) || (rs2_used && ex_q.rd == ir[24:20]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush_e) begin
      ex_q <= '0;
    end else if (!hold_e) begin
      ex_q <= stall_req ? '0 : dec;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_link      = ex_q.link;
  assign ex_imm       = ex_q.imm;
  assign ex_target    = ex_q.target;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_rd        = ex_q.rd;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7b5  = ex_q.funct7b5;
  assign ex_reg_we    = ex_q.reg_we;
  assign ex_is_load   = ex_q.is_load;
  assign ex_is_store  = ex_q.is_store;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_is_jal    = ex_q.is_jal;
  assign ex_is_jalr   = ex_q.is_jalr;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized stream vs a behavioural model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir, npc;
  logic        hold_e, flush_e, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        stall_req, ex_valid, ex_funct7b5, ex_reg_we;
  logic        ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal;
  logic [31:0] ex_pc, ex_link, ex_imm, ex_target, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk          (clk),
    .reset        (reset),
    .ir           (ir),
    .npc          (npc),
    .hold_e       (hold_e),
    .flush_e      (flush_e),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall_req    (stall_req),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_link      (ex_link),
    .ex_imm       (ex_imm),
    .ex_target    (ex_target),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .ex_rd        (ex_rd),
    .ex_opcode    (ex_opcode),
    .ex_funct3    (ex_funct3),
    .ex_funct7b5  (ex_funct7b5),
    .ex_reg_we    (ex_reg_we),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .ex_illegal   (ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, link, imm, target, v1, v2;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        we, ld, st, br, jal, jalr, ill;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        mex;
  logic [31:0] mrf [32];
  logic        last_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sign-extend the low 'bits' bits of v as a two's-complement number.
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    if (((v >> (bits - 1)) & 32'd1) != 0) return v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [31:0] fld(input logic [31:0] i, input int lo, input int w);
    return (i >> lo) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_we && wb_rd == a) return wb_data;
    return mrf[a];
  endfunction

  function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic w;
    e = '0;
    w = 1'b0;
    if (i == 32'h0) return e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.link  = pc + 32'd4;
    e.rs1   = 5'(fld(i, 15, 5));
    e.rs2   = 5'(fld(i, 20, 5));
    e.rd    = 5'(fld(i, 7, 5));
    e.op    = 7'(fld(i, 0, 7));
    e.f3    = 3'(fld(i, 12, 3));
    e.f7    = fld(i, 30, 1) != 0;
    e.v1    = rf_read(e.rs1);
    e.v2    = rf_read(e.rs2);
    case (e.op)
      7'h37, 7'h17: begin e.imm = i & 32'hFFFF_F000; w = 1'b1; end
      7'h6F: begin
        e.imm = sx(fld(i, 31, 1) * 32'h10_0000 + fld(i, 12, 8) * 32'h1000
                   + fld(i, 20, 1) * 32'h800 + fld(i, 21, 10) * 2, 21);
        e.jal = 1'b1; w = 1'b1;
      end
      7'h67: begin e.imm = sx(fld(i, 20, 12), 12); e.jalr = 1'b1; w = 1'b1; end
      7'h63: begin
        e.imm = sx(fld(i, 31, 1) * 4096 + fld(i, 7, 1) * 2048
                   + fld(i, 25, 6) * 32 + fld(i, 8, 4) * 2, 13);
        e.br = 1'b1;
      end
      7'h03: begin e.imm = sx(fld(i, 20, 12), 12); e.ld = 1'b1; w = 1'b1; end
      7'h23: begin e.imm = sx(fld(i, 25, 7) * 32 + fld(i, 7, 5), 12); e.st = 1'b1; end
      7'h13: begin e.imm = sx(fld(i, 20, 12), 12); w = 1'b1; end
      7'h33: w = 1'b1;
      default: e.ill = 1'b1;
    endcase
    if (e.br || e.jal) e.target = pc + e.imm;
    e.we = w && e.rd != 0;
    return e;
  endfunction

  function automatic logic model_stall(input logic [31:0] i);
    logic [6:0] op;
    logic       u1, u2;
    op = 7'(fld(i, 0, 7));
    u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    return mex.valid && mex.ld && mex.rd != 0 &&
           ((u1 && mex.rd == fld(i, 15, 5)) || (u2 && mex.rd == fld(i, 20, 5)));
  endfunction

  task automatic compare_ex();
    check_eq("ex_pc", ex_pc, mex.pc);
    check_eq("ex_link", ex_link, mex.link);
    check_eq("ex_imm", ex_imm, mex.imm);
    check_eq("ex_target", ex_target, mex.target);
    check_eq("ex_rs1_val", ex_rs1_val, mex.v1);
    check_eq("ex_rs2_val", ex_rs2_val, mex.v2);
    check_eq("ex_fields", 32'({ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5}),
             32'({mex.rs1, mex.rs2, mex.rd, mex.op, mex.f3, mex.f7}));
    check_eq("ex_flags", 32'({ex_valid, ex_reg_we, ex_is_load, ex_is_store, ex_is_branch,
                              ex_is_jal, ex_is_jalr, ex_illegal}),
             32'({mex.valid, mex.we, mex.ld, mex.st, mex.br, mex.jal, mex.jalr, mex.ill}));
  endtask

  task automatic cycle(input logic [31:0] i, input logic [31:0] pc, input logic h,
                       input logic f, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd);
    exp_t nxt;
    logic st;
    ir = i; npc = pc; hold_e = h; flush_e = f;
    wb_we = we; wb_rd = wr; wb_data = wd;
    #1;
    st = model_stall(i);
    check_eq("stall_req", 32'(stall_req), 32'(st));
    if (f)       nxt = '0;
    else if (h)  nxt = mex;
    else if (st) nxt = '0;
    else         nxt = model_decode(i, pc);
    last_stall = st;
    @(posedge clk);
    mex = nxt;
    if (we && wr != 0) mrf[wr] = wd;
    #1;
    compare_ex();
  endtask

  task automatic model_reset();
    mex = '0;
    for (int r = 0; r < 32; r++) mrf[r] = 32'h0;
  endtask

  task automatic random_stream(input int n);
    logic [31:0] i, pc;
    logic [6:0]  ops [10];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33};
    i = 32'h0; pc = 32'h0;
    for (int k = 0; k < n; k++) begin
      if (!last_stall) begin
        int kind;
        kind = $urandom_range(0, 11);
        i = $urandom;
        if (kind < 10) begin
          i[6:0]   = ops[kind];
          i[11:7]  = 5'($urandom_range(0, 7));
          i[19:15] = 5'($urandom_range(0, 7));
          i[24:20] = 5'($urandom_range(0, 7));
        end else if (kind == 10) begin
          i = 32'h0;
        end
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hC)
                                          : $urandom & 32'hFFFF_FFFC;
      end
      cycle(i, pc, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; ir = '0; npc = '0; hold_e = 1'b0; flush_e = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; last_stall = 1'b0;
    model_reset();
    #2;
    check_eq("rst_valid", 32'(ex_valid), 32'h0);
    check_eq("rst_stall", 32'(stall_req), 32'h0);
    compare_ex();
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;

    // addi x1,x0,5
    cycle(32'h0050_0093, 32'h8000, 0, 0, 0, 0, 0);
    check_eq("t2_valid", 32'(ex_valid), 32'h1);
    check_eq("t2_rd", 32'(ex_rd), 32'h1);
    check_eq("t2_imm", ex_imm, 32'h5);
    check_eq("t2_we", 32'(ex_reg_we), 32'h1);
    check_eq("t2_pc", ex_pc, 32'h8000);

    // add x3,x2,x2 with x2 written by WB in the same cycle
    cycle(32'h0021_01B3, 32'h8004, 0, 0, 1, 2, 32'hDEAD_BEEF);
    check_eq("t3_rs1", ex_rs1_val, 32'hDEAD_BEEF);
    check_eq("t3_rs2", ex_rs2_val, 32'hDEAD_BEEF);

    // beq x0,x0,-8
    cycle(32'hFE00_0CE3, 32'h8010, 0, 0, 0, 0, 0);
    check_eq("t4_br", 32'(ex_is_branch), 32'h1);
    check_eq("t4_imm", ex_imm, 32'hFFFF_FFF8);
    check_eq("t4_tgt", ex_target, 32'h8008);
    check_eq("t4_we", 32'(ex_reg_we), 32'h0);

    // jal x1,+8 at the top of the address space wraps
    cycle(32'h0080_00EF, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    check_eq("wrap_tgt", ex_target, 32'h4);
    check_eq("wrap_link", ex_link, 32'h0);

    // lw x5,0(x1) then dependent add x6,x5,x0
    cycle(32'h0000_A283, 32'h8020, 0, 0, 0, 0, 0);
    ir = 32'h0002_8333;
    #1;
    check_eq("t5_stall", 32'(stall_req), 32'h1);
    cycle(32'h0002_8333, 32'h8024, 0, 0, 0, 0, 0);
    check_eq("t5_bubble", 32'(ex_valid), 32'h0);
    cycle(32'h0002_8333, 32'h8024, 0, 0, 0, 0, 0);
    check_eq("t5_reissue", 32'(ex_rs1), 32'h5);

    cycle(32'h0050_0093, 32'h8030, 1, 1, 1, 0, 32'h1234);
    check_eq("t6_flush", 32'(ex_valid), 32'h0);
    cycle(32'h0000_03B3, 32'h8034, 0, 0, 0, 0, 0);
    check_eq("t6_x0", ex_rs1_val, 32'h0);
    cycle(32'h0000_007F, 32'h8038, 0, 0, 0, 0, 0);
    check_eq("t6_ill", 32'(ex_illegal), 32'h1);
    check_eq("t6_ill_we", 32'(ex_reg_we), 32'h0);

    last_stall = 1'b0;
    random_stream(300);

    // Fill every register, then reset mid-stream between clock edges.
    for (int r = 1; r < 32; r++) cycle(32'h0, 32'h0, 0, 0, 1, 5'(r), 32'hA500_0000 | r);
    cycle(32'h0000_A283, 32'h9000, 0, 0, 0, 0, 0);
    ir = 32'h0002_8333; hold_e = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(ex_valid), 32'h0);
    check_eq("mid_rst_stall", 32'(stall_req), 32'h0);
    model_reset();
    compare_ex();
    @(posedge clk); #3;
    reset = 1'b0;
    for (int r = 1; r < 32; r++) begin
      logic [31:0] i;
      i = 32'h0000_0033 | (32'(r) << 15) | (32'(r) << 20);
      cycle(i, 32'h100, 0, 0, 0, 0, 0);
      check_eq("clr_rd", ex_rs1_val, 32'h0);
    end

    last_stall = 1'b0;
    random_stream(300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
